spi_uart_tx: RTL
================

// Module: spi_uart_tx
// PURPOSE
//  Downstream stage of the ADS1293 SPI reader: captures each byte presented on
//  data_in when data_valid rises (driven from the reader's data_out/done).
//  Buffers bytes in a small FIFO and serialises them as 8N1 UART frames on tx.
//  Decouples the SPI burst rate from the slower host serial link.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        115200      UART bit rate; DIV = CLK_FREQ/BAUD (integer, truncated; 434 at defaults)
//  FIFO_AW     4           FIFO address width; depth = 2**FIFO_AW (16 at defaults)
// PORTS
//  clk         in   1          system clock, rising-edge
//  rst_n       in   1          asynchronous active-low reset
//  data_in     in   8          byte from SPI reader
//  data_valid  in   1          byte-ready strobe/level (SPI reader done)
//  ovf_clr     in   1          synchronous clear of overflow flag
//  tx          out  1          UART serial output, idle high
//  busy        out  1          high while a frame is on tx or the FIFO is non-empty
//  fifo_level  out  FIFO_AW+1  bytes currently buffered, 0..2**FIFO_AW
//  overflow    out  1          sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async, rst_n=0): tx=1, busy=0, fifo_level=0, overflow=0, FSM=IDLE,
//    FIFO pointers cleared. Reset mid-frame aborts the frame; tx returns high immediately.
//  - Capture: rising edge of data_valid (registered 0->1), not its level. A level held
//    high for N cycles writes exactly one byte; data_in is sampled in the first high cycle.
//  - Push accepted when fifo_level < depth, OR when a pop occurs in the same cycle
//    (level unchanged). Otherwise the byte is dropped and overflow is set.
//  - overflow stays set until ovf_clr=1 (sampled on clk). If ovf_clr and a new drop
//    occur in the same cycle, the drop wins: overflow stays 1.
//  - Pointers wrap modulo 2**FIFO_AW; full/empty come from fifo_level, not pointer compare.
//  - TX FSM: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP,
//    see CONFIGURATION).
//    IDLE: if FIFO non-empty, pop into shift register, go to START next cycle.
//    START: tx=0 for DIV clocks. DATA: 8 bits LSB first, DIV clocks each (3-bit counter).
//    STOP: tx=1 for DIV clocks, then IDLE. Back-to-back bytes add exactly 1 idle
//    cycle between frames (the IDLE pop cycle).
//  - Baud counter: counts 0..DIV-1, reloads at every state/bit boundary. tx is a
//    registered output, so there are no glitches.
//  - Latency: an isolated data_valid rise with an empty FIFO gives a tx falling edge
//    3 clocks later (edge register, FIFO write, IDLE pop).
//  - busy = (FSM != IDLE) | (fifo_level != 0), registered.
// CONFIGURATION
//  UART_PARITY_EN defined: adds PARITY state after DATA. tx = even parity (XOR of
//    the 8 data bits) for DIV clocks; frame = 11 bits (8E1).
//  Undefined: no PARITY state; frame = 10 bits (8N1).
// TESTING
//  1. Reset with defaults -> tx=1, busy=0, fifo_level=0, overflow=0; assert rst_n
//     mid-frame -> tx=1 the same cycle.
//  2. Push 0xA5 -> tx pattern 0,1,0,1,0,0,1,0,1,1 at 434 clk/bit; busy low 4340+3 clks
//     after push (8N1). With UART_PARITY_EN: parity bit 0, 11 bits, 4774 clks.
//  3. Hold data_valid high 50 cycles with data_in=0x3C -> exactly one frame is sent;
//     fifo_level peaks at 1.
//  4. Push 0x00..0x11 (18 bytes) back-to-back, one pulse every 2 clks -> the first byte
//     pops straight to the shifter, 16 are buffered, 1 is dropped; overflow=1,
//     fifo_level=16. Received order is 0x00..0x10 with 1 idle clk between frames.
//  5. With overflow=1, pulse ovf_clr -> overflow=0. ovf_clr coincident with a drop
//     -> overflow stays 1.
//  6. FIFO full, and a push coincides with the IDLE pop -> push accepted,
//     fifo_level stays 16, overflow unchanged.

Source files
------------

// File: rtl/spi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_uart_tx
// Brief    : Byte FIFO plus UART transmitter behind the ADS1293 SPI reader.
//            Define UART_PARITY_EN for 8E1 frames (default build is 8N1).
// Revision : 1.0 - initial release
// ============================================================================
module spi_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    input  logic               ovf_clr,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int                 c_div        = CLK_FREQ / BAUD;
    localparam int                 c_cnt_w      = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int                 c_depth      = 2 ** FIFO_AW;
    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(c_div - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [FIFO_AW:0]   c_full_level = (FIFO_AW + 1)'(c_depth);
    localparam logic [FIFO_AW:0]   c_lvl_one    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_ptr_one    = FIFO_AW'(1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    logic               r_dv_q;
    logic               r_wr_req;
    logic [7:0]         r_wr_data;
    logic [7:0]         r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
`ifdef UART_PARITY_EN
    logic               r_par;
`endif

    logic               w_rise;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;
    logic               w_baud_done;
    logic               w_frame_end;
    logic               w_busy_nxt;
    logic [FIFO_AW:0]   w_level_nxt;

    assign w_rise      = data_valid & ~r_dv_q;
    assign w_full      = (r_level == c_full_level);
    assign w_empty     = (r_level == '0);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still takes a byte when the transmitter frees a slot this cycle.
    assign w_push_ok   = r_wr_req && (!w_full || w_pop);
    assign w_drop      = r_wr_req && w_full && !w_pop;
    assign w_baud_done = (r_baud_cnt == c_div_last);
    assign w_frame_end = (r_state == S_STOP) && w_baud_done;
    assign w_busy_nxt  = w_pop || ((r_state != S_IDLE) && !w_frame_end) || (w_level_nxt != '0);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok && !w_pop) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (!w_push_ok && w_pop) begin
            w_level_nxt = r_level - c_lvl_one;
        end
    end

    assign fifo_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv_q    <= 1'b0;
            r_wr_req  <= 1'b0;
            r_wr_data <= 8'h00;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            overflow  <= 1'b0;
        end else begin
            r_dv_q   <= data_valid;
            r_wr_req <= w_rise;
            if (w_rise) begin
                r_wr_data <= data_in;
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            r_level <= w_level_nxt;
            // A fresh drop outranks a simultaneous clear request.
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
`ifdef UART_PARITY_EN
            r_par      <= 1'b0;
`endif
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            busy <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rptr];
`ifdef UART_PARITY_EN
                        r_par      <= ^r_mem[r_rptr];
`endif
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                        tx         <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        tx         <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx      <= r_par;
                            r_state <= S_PARITY;
`else
                            tx      <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            tx        <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        tx         <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    tx         <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
